// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arbiter
//  Brief    : Two-requester (instruction fetch / data) arbiter and sequencer
//             driving a single SRAM converter port with registered commands.
//             Define SRAM_ARB_RR_EN for round-robin tie breaking; the default
//             build uses fixed data-over-instruction priority.
//  Revision : 1.0  initial release
// ============================================================================
module sram_arbiter #(
    parameter int WR_WAIT = 1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    localparam logic       c_OWN_INSTR = 1'b0;
    localparam logic       c_OWN_DATA  = 1'b1;
    localparam logic [2:0] c_WCNT_INIT = WR_WAIT[2:0];

    state_t      r_state;
    logic        r_owner;
    logic        r_last;
    logic [2:0]  r_wcnt;
    logic        r_en;
    logic [3:0]  r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_rsp_pend;
    logic        r_rsp_owner;

    logic        w_idle;
    logic        w_data_wins_tie;
    logic        w_pick_d;
    logic        w_gnt_i;
    logic        w_gnt_d;
    logic        w_is_wr;

`ifdef SRAM_ARB_RR_EN
    assign w_data_wins_tie = (r_last == c_OWN_INSTR);
`else
    // Fixed priority: last is still tracked but cannot change the outcome.
    assign w_data_wins_tie = r_last | 1'b1;
`endif

    assign w_idle   = (r_state == S_IDLE) && !resetn;
    assign w_pick_d = d_req && (!i_req || w_data_wins_tie);
    assign w_gnt_d  = w_idle && w_pick_d;
    assign w_gnt_i  = w_idle && i_req && !w_pick_d;
    assign w_is_wr  = w_gnt_d && (d_we != 4'h0);

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state     <= S_IDLE;
            r_owner     <= c_OWN_INSTR;
            r_last      <= c_OWN_INSTR;
            r_wcnt      <= 3'd0;
            r_en        <= 1'b0;
            r_we        <= 4'h0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_rsp_pend  <= 1'b0;
            r_rsp_owner <= c_OWN_INSTR;
        end else begin
            r_rsp_pend <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_i || w_gnt_d) begin
                        r_owner <= w_gnt_d ? c_OWN_DATA : c_OWN_INSTR;
                        r_last  <= w_gnt_d ? c_OWN_DATA : c_OWN_INSTR;
                        r_en    <= 1'b1;
                        r_addr  <= w_gnt_d ? d_addr : i_addr;
                        r_we    <= w_gnt_d ? d_we : 4'h0;
                        r_wdata <= w_is_wr ? d_wdata : 32'h0;
                        r_wcnt  <= c_WCNT_INIT;
                        r_state <= w_is_wr ? S_WR : S_RD;
                    end
                end
                S_RD: begin
                    r_en        <= 1'b0;
                    r_we        <= 4'h0;
                    r_addr      <= 32'h0;
                    r_wdata     <= 32'h0;
                    r_rsp_pend  <= 1'b1;
                    r_rsp_owner <= r_owner;
                    r_state     <= S_IDLE;
                end
                S_WR: begin
                    if (r_wcnt == 3'd0) begin
                        r_en        <= 1'b0;
                        r_we        <= 4'h0;
                        r_addr      <= 32'h0;
                        r_wdata     <= 32'h0;
                        r_rsp_pend  <= 1'b1;
                        r_rsp_owner <= r_owner;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wcnt <= r_wcnt - 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign i_gnt      = w_gnt_i;
    assign d_gnt      = w_gnt_d;
    assign i_rvalid   = r_rsp_pend && (r_rsp_owner == c_OWN_INSTR);
    assign d_rvalid   = r_rsp_pend && (r_rsp_owner == c_OWN_DATA);
    assign i_rdata    = i_rvalid ? sram_rdata : 32'h0;
    assign d_rdata    = d_rvalid ? sram_rdata : 32'h0;

    assign sram_en    = r_en;
    assign sram_we    = r_we;
    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_arbiter
//  Brief    : Randomized scoreboard bench for sram_arbiter with a converter
//             model and a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int WR_WAIT = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = 32'h0;

    sram_arbiter #(.WR_WAIT(WR_WAIT)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        wr;
        logic [31:0] data;
    } exp_t;

    exp_t        iq[$];
    exp_t        dq[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    bit          run        = 1'b1;
    bit          rd_grant_now = 1'b0;
    logic [31:0] conv_mem [0:1023];
    logic [31:0] ref_mem  [0:1023];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h8000_0000 | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @cyc %0d: actual %0h required %0h", name, cyc, act, exp);
        end
    endtask

    // Converter model: registered read data, byte-masked writes.
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we == 4'h0)
                sram_rdata <= conv_mem[sram_addr[11:2]];
            else
                conv_mem[sram_addr[11:2]] <= merge(conv_mem[sram_addr[11:2]], sram_wdata, sram_we);
        end
    end

    // Instruction requester
    initial begin : p_ireq
        bit g;
        i_req  = 1'b1;
        i_addr = 32'h8000_0010;
        @(posedge clk);
        forever begin
            @(negedge clk);
            g = i_gnt;
            @(posedge clk);
            #1;
            if (g) i_req = 1'b0;
            if (!i_req && run && $urandom_range(0, 3) != 0) begin
                i_req  = 1'b1;
                i_addr = rand_addr();
            end
        end
    end

    // Data requester
    initial begin : p_dreq
        bit g;
        d_req   = 1'b1;
        d_we    = 4'b0100;
        d_addr  = 32'h8040_0002;
        d_wdata = 32'h00AB_0000;
        @(posedge clk);
        forever begin
            @(negedge clk);
            g = d_gnt;
            @(posedge clk);
            #1;
            if (g) d_req = 1'b0;
            if (!d_req && run && $urandom_range(0, 3) != 0) begin
                d_req   = 1'b1;
                d_addr  = rand_addr();
                d_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                d_wdata = $urandom;
            end
        end
    end

    // Reference model: predicts bus activity, grants and responses per cycle.
    initial begin : p_model
        int          m_busy;
        bit          m_last;
        logic [3:0]  m_we;
        logic [31:0] m_addr, m_wdata;
        bit          win_i, win_d;
        exp_t        e;
        m_busy = 0; m_last = 1'b0; m_we = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #1;
            if (m_busy > 0)
                check("sram_bus", {sram_en, sram_we, sram_addr, sram_wdata},
                      {1'b1, m_we, m_addr, (m_we != 4'h0) ? m_wdata : 32'h0});
            else
                check("sram_bus", {sram_en, sram_we, sram_addr, sram_wdata}, 69'h0);
            win_i = 1'b0;
            win_d = 1'b0;
            if (m_busy == 0 && !resetn) begin
                if (d_req && i_req) begin
`ifdef SRAM_ARB_RR_EN
                    win_d = !m_last;
`else
                    win_d = 1'b1;
`endif
                end else begin
                    win_d = d_req;
                end
                win_i = i_req && !win_d;
            end
            check("gnt", {i_gnt, d_gnt}, {win_i, win_d});
            rd_grant_now = 1'b0;
            if (resetn) begin
                m_busy = 0;
                m_last = 1'b0;
                iq.delete();
                dq.delete();
            end else begin
                if (m_busy > 0) m_busy--;
                if (win_i || win_d) begin
                    m_we    = win_d ? d_we : 4'h0;
                    m_addr  = win_d ? d_addr : i_addr;
                    m_wdata = d_wdata;
                    m_busy  = (m_we == 4'h0) ? 1 : WR_WAIT + 1;
                    m_last  = win_d;
                    e.due   = cyc + 1 + m_busy;
                    e.wr    = (m_we != 4'h0);
                    if (e.wr) begin
                        ref_mem[m_addr[11:2]] = merge(ref_mem[m_addr[11:2]], m_wdata, m_we);
                        e.data = 32'h0;
                    end else begin
                        e.data = ref_mem[m_addr[11:2]];
                    end
                    if (win_d) dq.push_back(e);
                    else       iq.push_back(e);
                    rd_grant_now = !e.wr;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever a response is presented.
    initial begin : p_monitor
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (i_rvalid) begin
                if (iq.size() == 0) begin
                    check("i_rvalid_unexpected", 1, 0);
                end else begin
                    e = iq.pop_front();
                    check("i_rvalid_cycle", cyc, e.due);
                    check("i_rdata", i_rdata, e.data);
                end
            end else begin
                check("i_rdata_gated", i_rdata, 32'h0);
                if (iq.size() > 0 && iq[0].due <= cyc) begin
                    check("i_rvalid_missing", 0, 1);
                    void'(iq.pop_front());
                end
            end
            if (d_rvalid) begin
                if (dq.size() == 0) begin
                    check("d_rvalid_unexpected", 1, 0);
                end else begin
                    e = dq.pop_front();
                    check("d_rvalid_cycle", cyc, e.due);
                    if (!e.wr) check("d_rdata", d_rdata, e.data);
                end
            end else begin
                check("d_rdata_gated", d_rdata, 32'h0);
                if (dq.size() > 0 && dq[0].due <= cyc) begin
                    check("d_rvalid_missing", 0, 1);
                    void'(dq.pop_front());
                end
            end
        end
    end

    initial begin : p_main
        bit found;
        resetn = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i]  = $urandom;
            conv_mem[i] <= ref_mem[i];
        end
        ref_mem[4]  = 32'h2402_0001;
        conv_mem[4] <= 32'h2402_0001;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b0;

        for (int k = 0; k < 3; k++) begin
            repeat (400) @(posedge clk);
            found = 1'b0;
            for (int t = 0; t < 300 && !found; t++) begin
                @(negedge clk);
                #2;
                found = rd_grant_now;
            end
            if (!found) begin
                compared++;
                mismatched++;
                $display("FAIL mid_read_reset: actual no read grant within 300 cycles, required one");
            end else begin
                @(posedge clk);
                #1 resetn = 1'b1;
                @(posedge clk);
                #1 resetn = 1'b0;
            end
        end

        repeat (400) @(posedge clk);
        run = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        #3;
        check("iq_drained", iq.size(), 0);
        check("dq_drained", dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester arbiter and sequencer in front of the SRAM converter. Shares one BaseRAM/ExtRAM port between the CPU instruction-fetch port (read-only) and the data port (read/write). Drives the converter's `cpu_sram_*` side with registered, single-owner transactions. Returns read data and write acknowledges to the winning requester.

## Interface
- `WR_WAIT`, default 1: extra cycles `sram_en`/`sram_we` are held beyond the first write cycle (write pulse = `WR_WAIT+1` cycles); legal range 0..7.
- `clk` in 1: single clock.
- `resetn` in 1: reset, **synchronous and active-high** (1 = reset; the codebase's port name is retained).
- `i_req` in 1: instruction read request. Held with `i_addr` stable until `i_gnt`.
- `i_addr` in 32: instruction byte address.
- `i_gnt` out 1: one-cycle accept pulse for the instruction port.
- `i_rvalid` out 1: one-cycle pulse; `i_rdata` is valid.
- `i_rdata` out 32: instruction read data.
- `d_req` in 1: data request. Held with `d_we`/`d_addr`/`d_wdata` stable until `d_gnt`.
- `d_we` in 4: byte write mask, active-high. `4'h0` means a read.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: write data.
- `d_gnt` out 1: one-cycle accept pulse for the data port.
- `d_rvalid` out 1: one-cycle pulse; read data valid, or write complete.
- `d_rdata` out 32: data read data.
- `sram_en` out 1: to converter `cpu_sram_en`.
- `sram_we` out 4: to converter `cpu_sram_we`.
- `sram_addr` out 32: to converter `cpu_sram_addr`. Full byte address; the converter slices `[21:2]`.
- `sram_wdata` out 32: to converter `cpu_sram_wdata`.
- `sram_rdata` in 32: from converter `cpu_sram_rdata`. Registered by the converter, valid the cycle after a read-enable cycle.

## Operation
- **FSM states:** IDLE, RD, WR.
- **Command latch:** `owner`, `addr`, `we`, `wdata`.
- **Write counter:** 3-bit `wcnt`.
- **Last-winner flag:** `last` (0 = instr, 1 = data).

**IDLE**
- If any request is present, select a winner and pulse its `gnt` combinationally in this cycle.
- Latch the winner's command.
- Go to RD if the latched `we == 0`, otherwise go to WR and load `wcnt = WR_WAIT`.
- Set `last` to the winner.
- With no request, stay in IDLE.

**RD** (exactly 1 cycle)
- `sram_en = 1`, `sram_we = 0`, `sram_addr` = latched address.
- Next state is IDLE.
- Set the registered flag `rsp_pend`/`rsp_owner`.

**WR** (`WR_WAIT+1` cycles)
- `sram_en = 1`; `sram_we`, `sram_addr`, `sram_wdata` are the latched values.
- `wcnt` decrements each cycle; when it reaches 0, go to IDLE and set `rsp_pend`.

**Response**
- In the IDLE cycle following RD or WR, `rsp_pend = 1`.
- The owner's `rvalid` = 1 for that cycle only.
- `i_rdata` and `d_rdata` are `sram_rdata` passed through, qualified by `rvalid`.
- For a write, `d_rvalid` is the ack and `d_rdata` is don't-care.
- A new grant may occur in that same IDLE cycle.

**Arbitration**
- Fixed priority: data beats instruction (see Configuration for the alternative).
- Only one transaction is in flight; requests are never reordered within a port.
- A `req` that deasserts before `gnt` is a protocol violation; its behaviour is undefined.

**Outputs**
- `sram_*` are registered and reflect state only: 0 in IDLE.
- `sram_wdata` is 0 except in WR.

## Timing
- **Read:** `gnt` in cycle 0, RD (`sram_en`) in cycle 1, `rvalid` in cycle 2. Latency 2; peak throughput 1 read per 2 cycles.
- **Write:** `gnt` in cycle 0, WR in cycles 1..`1+WR_WAIT`, `d_rvalid` in cycle `2+WR_WAIT`.
- `i_gnt` and `d_gnt` are never high in the same cycle.
- `i_rvalid` and `d_rvalid` are never high in the same cycle.
- **Reset** (`resetn = 1` sampled at a `clk` edge): after that edge, state = IDLE and `rsp_pend = 0`.
  - All outputs are 0: `gnt`, `rvalid`, `sram_en`, `sram_we`, `sram_addr`, `sram_wdata`, and `rdata` (gated by `rvalid`).
  - `last` = 0 (instr), so data wins the first tie under round-robin.
- **Reset mid-transaction:** the transaction is dropped, no `rvalid` is issued, and `sram_en` is low on the next cycle.
- **Write with `d_we` = 4'hF vs partial mask:** identical timing; only the latched mask differs.

## Configuration
- `SRAM_ARB_RR_EN` defined:
  - On a tie (both requests present in IDLE), the port not equal to `last` wins, giving strict alternation under continuous contention.
  - With a single requester, that requester wins regardless of `last`.
- `SRAM_ARB_RR_EN` undefined:
  - Data always wins ties; instruction fetch may starve while `d_req` is continuously high.
  - `last` is still maintained but unused.

## Test plan
- **Reset:** hold `resetn = 1` for 3 cycles with both reqs high → all outputs 0, no `gnt`; release → `d_gnt` at the first IDLE cycle in both configurations.
- **Instruction read:** `i_req`, `i_addr = 32'h8000_0010`, converter model returns `32'h2402_0001` → `i_gnt` in cycle 0, `sram_en = 1`/`sram_we = 0`/`sram_addr = 32'h8000_0010` in cycle 1, `i_rvalid` with `i_rdata = 32'h2402_0001` in cycle 2.
- **Data byte write:** `WR_WAIT = 2`, `d_we = 4'b0100`, `d_addr = 32'h8040_0002`, `d_wdata = 32'h00AB_0000` → `sram_we = 4'b0100` held for cycles 1–3, `d_rvalid` in cycle 4, `i_rvalid` stays 0.
- **Contention, 8 cycles with both reqs high:**
  - Without `SRAM_ARB_RR_EN`: 4 `d_gnt`, 0 `i_gnt`.
  - With `SRAM_ARB_RR_EN`: grants alternate d, i, d, i.
- **Back-to-back:** a new request granted in the `rvalid` cycle → next `sram_en` is in the following cycle, with no bubble beyond the 2-cycle cadence.
- **Mid-read reset:** assert `resetn` in the RD cycle → no `rvalid`, `sram_en = 0` next cycle, and a fresh request afterwards completes normally.
